// File: rtl/pipe_issue_sched.sv
// Issue scheduler: inserts NOP bubbles for MEM-port and accumulator hazards.
// Optional SCHED_PERF_EN adds issue/stall counters; bit positions match pipe_defs.vh.
module pipe_issue_sched #(
  parameter int LD_DATA_OFS  = 1,
  parameter int LD_COEFF_OFS = 2,
  parameter int WRITE_OFS    = 3,
  parameter int ADD_LAT      = 3,
  parameter int WIN          = 8,
  parameter int NOP          = 0,
  parameter int LD_DATA      = 1,
  parameter int LD_COEFF     = 2,
  parameter int ADD          = 3,
  parameter int MULT         = 4,
  parameter int WRITE        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_inst,
  output logic [7:0]  inst,
  output logic        stall,
  output logic        busy,
`ifdef SCHED_PERF_EN
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt,
`endif
  output logic        err
);

  localparam int AW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [7:0] NOP_W = 8'(1) << NOP;
  localparam logic [WIN-1:0] M_LD = WIN'(1) << LD_DATA_OFS;
  localparam logic [WIN-1:0] M_CO = WIN'(1) << LD_COEFF_OFS;
  localparam logic [WIN-1:0] M_WR = WIN'(1) << WRITE_OFS;
  localparam logic EQ_LC = (LD_DATA_OFS == LD_COEFF_OFS);
  localparam logic EQ_LW = (LD_DATA_OFS == WRITE_OFS);
  localparam logic EQ_CW = (LD_COEFF_OFS == WRITE_OFS);

  logic           pend_valid;
  logic [7:0]     pend;
  logic [WIN-1:0] res;
  logic [WIN-1:0] want;
  logic [WIN-1:0] res_set;
  logic [AW-1:0]  acc_wait;
  logic           has_ld;
  logic           has_co;
  logic           has_wr;
  logic           conflict;
  logic           mem_hit;
  logic           acc_hit;
  logic           hazard;
  logic           issue_now;
  logic           take;

  always_comb begin
    has_ld    = pend[LD_DATA];
    has_co    = pend[LD_COEFF];
    has_wr    = pend[WRITE];
    want      = ({WIN{has_ld}} & M_LD)
              | ({WIN{has_co}} & M_CO)
              | ({WIN{has_wr}} & M_WR);
    conflict  = (has_ld & has_co & EQ_LC)
              | (has_ld & has_wr & EQ_LW)
              | (has_co & has_wr & EQ_CW);
    mem_hit   = |(want & res);
    acc_hit   = has_wr & (acc_wait != '0);
    hazard    = pend_valid & ~conflict & (mem_hit | acc_hit);
    issue_now = pend_valid & ~hazard;
    take      = issue_now & ~conflict;
    res_set   = res | (take ? want : '0);
  end

  assign in_ready = ~pend_valid | issue_now;
  assign stall    = hazard;
  assign busy     = pend_valid | (|res);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend       <= NOP_W;
      res        <= '0;
      acc_wait   <= '0;
      inst       <= NOP_W;
      err        <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        pend_valid <= 1'b1;
        pend       <= in_inst;
      end else if (issue_now) begin
        pend_valid <= 1'b0;
      end
      // Window always advances one slot, whether or not a word issued
      res  <= res_set >> 1;
      inst <= take ? pend : NOP_W;
      if (take && pend[ADD])
        acc_wait <= AW'(ADD_LAT - 1);
      else if (acc_wait != '0)
        acc_wait <= acc_wait - AW'(1);
      if (issue_now && conflict)
        err <= 1'b1;
    end
  end

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (take && (pend != NOP_W) && (issue_cnt != 16'hFFFF))
        issue_cnt <= issue_cnt + 16'd1;
      if (hazard && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_issue_sched.sv
// Scoreboard bench for pipe_issue_sched against a slot-level reference model.
module tb_pipe_issue_sched;
  localparam int LDO  = 1;
  localparam int COO  = 2;
  localparam int WRO  = 3;
  localparam int ALAT = 3;
  localparam logic [7:0] N  = 8'h01;
  localparam logic [7:0] LD = 8'h02;
  localparam logic [7:0] CO = 8'h04;
  localparam logic [7:0] AD = 8'h08;
  localparam logic [7:0] MU = 8'h10;
  localparam logic [7:0] WR = 8'h20;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, stall, busy, err;
  logic [7:0] in_inst, inst;
  logic reset2, in_valid2, in_ready2, stall2, busy2, err2;
  logic [7:0] in_inst2, inst2;
`ifdef SCHED_PERF_EN
  logic [15:0] ic, sc, ic2, sc2;
`endif

  always #5 clk = ~clk;

  pipe_issue_sched dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_ready(in_ready), .in_inst(in_inst), .inst(inst),
    .stall(stall), .busy(busy),
`ifdef SCHED_PERF_EN
    .issue_cnt(ic), .stall_cnt(sc),
`endif
    .err(err)
  );

  pipe_issue_sched #(.LD_COEFF_OFS(1)) dut2 (
    .clk(clk), .reset(reset2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_inst(in_inst2), .inst(inst2),
    .stall(stall2), .busy(busy2),
`ifdef SCHED_PERF_EN
    .issue_cnt(ic2), .stall_cnt(sc2),
`endif
    .err(err2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] w;
  } exp_t;
  exp_t q[$];

  // Model state in absolute cycle numbers
  bit mem_busy[int];
  int max_busy = -1;
  int last_add = -100;
  int pend_issue = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               name, cyc, act, exp);
    end
  endtask

  function automatic bit mem_ok(logic [7:0] w, int c);
    if (w[1] && mem_busy.exists(c + LDO)) return 1'b0;
    if (w[2] && mem_busy.exists(c + COO)) return 1'b0;
    if (w[5] && mem_busy.exists(c + WRO)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void reserve(int t);
    mem_busy[t] = 1'b1;
    if (t > max_busy) max_busy = t;
  endfunction

  // Word accepted at the end of cycle n: find its issue slot
  function automatic void sched(logic [7:0] w, int n);
    int c;
    c = n + 2;
    for (int k = 0; k < 64; k++) begin
      if (mem_ok(w, c) && (!w[5] || c >= last_add + ALAT)) break;
      c++;
    end
    if (w[1]) reserve(c + LDO);
    if (w[2]) reserve(c + COO);
    if (w[5]) reserve(c + WRO);
    if (w[3]) last_add = c;
    if (w != N) q.push_back('{c: c, w: w});
    pend_issue = c;
  endfunction

  task automatic step(input bit v, input logic [7:0] w,
                      output bit acc);
    int n;
    bit m_ready, m_stall, m_busy;
    in_valid = v;
    in_inst  = w;
    @(negedge clk);
    n = cyc;
    m_ready = (pend_issue <= n + 1);
    m_stall = (pend_issue > n + 1);
    m_busy  = (pend_issue > n) || (max_busy > n);
    chk("in_ready", in_ready, m_ready);
    chk("stall", stall, m_stall);
    chk("busy", busy, m_busy);
    acc = v && m_ready;
    if (acc) sched(w, n);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    bit acc;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, w, acc);
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    bit acc;
    for (int i = 0; i < k; i++) step(1'b0, N, acc);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (inst != N) begin
          if (q.size() == 0) begin
            chk("unexpected_issue", inst, N);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("issue_word", inst, e.w);
            chk("issue_slot", cyc, e.c);
          end
        end else if (q.size() > 0 && q[0].c <= cyc) begin
          chk("missing_issue", inst, q[0].w);
          void'(q.pop_front());
        end
      end
    end
  end

  logic [7:0] pool [12] = '{N, LD, CO, AD, MU, WR, AD | MU,
                            LD | WR, CO | AD, WR | MU,
                            LD | CO, AD | WR};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = N;
    reset2 = 1'b1; in_valid2 = 1'b0; in_inst2 = N;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reset2 = 1'b0;
    @(negedge clk);
    chk("rst_inst", inst, N);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err2", err2, 0);
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    send(CO); send(LD); idle(6);
    send(CO); send(N); send(LD);
    send(AD | MU); send(AD | MU); send(WR); idle(10);
    send(WR); send(CO); idle(6);
    send(AD); send(WR); idle(6);
    send(AD); send(N); send(WR); idle(6);
    for (int i = 0; i < 4; i++) send(AD | MU);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(pool[$urandom_range(0, 11)]);
    end
    idle(12);
    chk("drain", q.size(), 0);
    chk("err_clean", err, 0);

    mon_on = 1'b0;
    q.delete();
    in_valid = 1'b1; in_inst = CO;
    @(posedge clk); #1;
    in_inst = LD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ld_stalled", stall, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_inst", inst, N);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall", stall, 0);

    @(posedge clk); #1;
    in_valid2 = 1'b1; in_inst2 = LD | CO;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("conf_nostall", stall2, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("conf_err", err2, 1);
    chk("conf_inst", inst2, N);
    chk("conf_ready", in_ready2, 1);
    chk("conf_busy", busy2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
